// File: rtl/datamem_responder.sv
// Byte-addressed, big-endian data memory answering LDUR/STUR requests with a
// fixed access latency behind valid/ready request and response handshakes.
module datamem_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [63:0] address,
   input  logic        write_enable,
   input  logic        read_enable,
   input  logic [63:0] write_data,
   input  logic [3:0]  xfer_size,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] read_data,
   output logic        error
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   counter;
   logic [63:0]        addr_q;
   logic               we_q;
   logic               re_q;
   logic [63:0]        wdata_q;
   logic [3:0]         size_q;
   logic [7:0]         mem [DEPTH];

   logic               accept;
   logic               finish;
   logic               req_err;
   logic [ADDR_W-1:0]  byte_addr;
   logic [6:0]         shift;
   logic [63:0]        load_be;
   logic [63:0]        load_val;
   logic [63:0]        store_be;

   // Full 65-bit end-address compare so a request near 2^64 cannot wrap into range.
   function automatic logic request_error(input logic [63:0] addr, input logic we,
                                          input logic re, input logic [3:0] size);
      logic [64:0] end_addr;
      logic        bad;
      end_addr = {1'b0, addr} + {61'd0, size};
      bad = we && re;
      if (!(size == 4'd1 || size == 4'd2 || size == 4'd4 || size == 4'd8))
         bad = 1'b1;
      else if ((addr[3:0] & (size - 4'd1)) != 4'd0)
         bad = 1'b1;
      if (end_addr > 65'(DEPTH))
         bad = 1'b1;
      return bad;
   endfunction

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign accept     = req_valid && req_ready;
   assign finish     = (state == BUSY) && (counter == '0);
   assign req_err    = request_error(addr_q, we_q, re_q, size_q);
   assign byte_addr  = addr_q[ADDR_W-1:0];
   assign shift      = {4'd8 - size_q, 3'b000};

   // Bytes are kept big-endian: the n-byte value is left-aligned, then byte i goes to address+i.
   always_comb begin
      load_be = '0;
      for (int i = 0; i < 8; i++)
         load_be[63-8*i -: 8] = mem[byte_addr + ADDR_W'(i)];
      load_val = load_be >> shift;
      store_be = wdata_q << shift;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = BUSY;
         BUSY: if (counter == '0) state_next = RESP;
         RESP: if (resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         counter   <= '0;
         read_data <= '0;
         error     <= 1'b0;
      end else begin
         state <= state_next;
         if (accept)
            counter <= CNT_INIT;
         else if (state == BUSY && counter != '0)
            counter <= counter - 1'b1;
         if (finish) begin
            error     <= req_err;
            read_data <= (re_q && !req_err) ? load_val : 64'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= address;
         we_q    <= write_enable;
         re_q    <= read_enable;
         wdata_q <= write_data;
         size_q  <= xfer_size;
      end
   end

   // A reset on the completion edge must drop the pending store.
   always_ff @(posedge clk) begin
      if (reset && finish && we_q && !req_err) begin
         for (int i = 0; i < 8; i++)
            if (4'(i) < size_q)
               mem[byte_addr + ADDR_W'(i)] <= store_be[63-8*i -: 8];
      end
   end

endmodule
